// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory request bus and instruction stream between fetch and its neighbours
interface fetch_unit_if;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [15:0] instr_pc;

  modport master (
    output mem_read, mem_address,
    input  mem_data,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_read, mem_address,
    output mem_data,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with one-cycle memory, FIFO buffer, redirect and range fault
module fetch_unit #(
  parameter int          DEPTH     = 2,
  parameter int          MEM_WORDS = 512,
  parameter logic [15:0] RESET_PC  = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         redirect,
  input  logic [15:0]  redirect_pc,
  output logic         fault,
  output logic [15:0]  fault_pc,
  fetch_unit_if.master bus
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              CW        = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [16:0]     MEM_LIMIT = 17'(MEM_WORDS);

  typedef enum logic [0:0] {RUN, FAULT} state_t;

  state_t        state, state_nx;
  logic [15:0]   pc;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   buf_data [DEPTH];
  logic [15:0]   buf_pc   [DEPTH];
  logic          pop, push, issue, fault_set, in_range;

  // mem_read doubles as the in-flight flag: a request always answers on the next edge
  assign in_range = {1'b0, pc} < MEM_LIMIT;
  assign pop      = bus.instr_valid && bus.instr_ready;
  assign push     = bus.mem_read && !redirect;
  assign free     = DEPTH_C - count - CW'(bus.mem_read) + CW'(pop);

  assign bus.instr_valid = (count != '0);
  assign bus.instr       = buf_data[rd_ptr];
  assign bus.instr_pc    = buf_pc[rd_ptr];

  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    fault_set = 1'b0;
    if (redirect) begin
      state_nx = RUN;
    end else if (state == RUN && enable) begin
      if (in_range) begin
        issue = (free != '0);
      end else begin
        fault_set = 1'b1;
        state_nx  = FAULT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_read    <= 1'b0;
      bus.mem_address <= 16'h0000;
      pc              <= RESET_PC;
      fault           <= 1'b0;
      fault_pc        <= 16'h0000;
      count           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
    end else begin
      bus.mem_read <= issue;
      if (issue) bus.mem_address <= pc;

      if (redirect)   pc <= redirect_pc;
      else if (issue) pc <= pc + 16'd1;

      if (redirect) begin
        fault <= 1'b0;
      end else if (fault_set) begin
        fault    <= 1'b1;
        fault_pc <= pc;
      end

      // redirect flushes the buffer and drops both the arriving word and any pop
      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= bus.mem_data;
      buf_pc[wr_ptr]   <= bus.mem_address;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        fault;
  logic [15:0] fault_pc;
  int          passed = 0;
  int          total  = 0;

  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(2), .MEM_WORDS(512), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fault      (fault),
    .fault_pc   (fault_pc),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // memory content: word at address a is {~a, a}
  assign bus.mem_data = {~bus.mem_address, bus.mem_address};

  function automatic logic [31:0] word(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    bus.instr_ready = 1'b0;
    #2;
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_pc", 32'(fault_pc), 32'd0);

    // sequential fetch
    #10; rst_n = 1'b1; enable = 1'b1; bus.instr_ready = 1'b1;
    step();
    check("seq_rd0", 32'(bus.mem_read), 32'd1);
    check("seq_addr0", 32'(bus.mem_address), 32'h0000);
    check("seq_valid0", 32'(bus.instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("seq_addr", 32'(bus.mem_address), 32'(i + 1));
      check("seq_valid", 32'(bus.instr_valid), 32'd1);
      check("seq_instr", bus.instr, word(16'(i)));
      check("seq_pc", 32'(bus.instr_pc), 32'(i));
    end

    // reset pulsed mid-stream between edges
    #3; rst_n = 1'b0; #1;
    check("mid_rst_read", 32'(bus.mem_read), 32'd0);
    check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);

    // backpressure from reset
    bus.instr_ready = 1'b0; #2; rst_n = 1'b1;
    step();
    check("bp_addr0", 32'(bus.mem_address), 32'h0000);
    check("bp_rd0", 32'(bus.mem_read), 32'd1);
    step();
    check("bp_addr1", 32'(bus.mem_address), 32'h0001);
    check("bp_rd1", 32'(bus.mem_read), 32'd1);
    step();
    check("bp_stall_rd", 32'(bus.mem_read), 32'd0);
    step();
    check("bp_stall_rd2", 32'(bus.mem_read), 32'd0);
    check("bp_hold_instr", bus.instr, word(16'h0000));
    check("bp_hold_pc", 32'(bus.instr_pc), 32'h0000);
    bus.instr_ready = 1'b1;
    step();
    check("bp_resume_rd", 32'(bus.mem_read), 32'd1);
    check("bp_resume_addr", 32'(bus.mem_address), 32'h0002);
    check("bp_resume_pc", 32'(bus.instr_pc), 32'h0001);
    step();
    check("bp_next_addr", 32'(bus.mem_address), 32'h0003);
    check("bp_next_pc", 32'(bus.instr_pc), 32'h0002);
    check("bp_next_instr", bus.instr, word(16'h0002));

    // redirect with word 3 in flight and word 2 buffered
    bus.instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    check("rd_flush_valid", 32'(bus.instr_valid), 32'd0);
    check("rd_no_req", 32'(bus.mem_read), 32'd0);
    step();
    check("rd_new_addr", 32'(bus.mem_address), 32'h0010);
    check("rd_new_rd", 32'(bus.mem_read), 32'd1);
    check("rd_no_stale", 32'(bus.instr_valid), 32'd0);
    bus.instr_ready = 1'b1;
    step();
    check("rd_head_pc", 32'(bus.instr_pc), 32'h0010);
    check("rd_head_instr", bus.instr, word(16'h0010));

    // enable low: no request, in-flight word 0x11 still captured
    enable = 1'b0;
    step();
    check("en_off_rd", 32'(bus.mem_read), 32'd0);
    check("en_off_pc", 32'(bus.instr_pc), 32'h0011);
    step();
    check("en_off_drain", 32'(bus.instr_valid), 32'd0);
    enable = 1'b1;

    // range fault near the top of memory
    redirect = 1'b1; redirect_pc = 16'h01FE;
    step();
    redirect = 1'b0;
    check("rf_redir_fault", 32'(fault), 32'd0);
    check("rf_redir_rd", 32'(bus.mem_read), 32'd0);
    step();
    check("rf_addr_1fe", 32'(bus.mem_address), 32'h01FE);
    step();
    check("rf_addr_1ff", 32'(bus.mem_address), 32'h01FF);
    check("rf_pc_1fe", 32'(bus.instr_pc), 32'h01FE);
    step();
    check("rf_fault", 32'(fault), 32'd1);
    check("rf_fault_pc", 32'(fault_pc), 32'h0200);
    check("rf_no_req", 32'(bus.mem_read), 32'd0);
    check("rf_drain_pc", 32'(bus.instr_pc), 32'h01FF);
    check("rf_drain_instr", bus.instr, word(16'h01FF));
    step();
    check("rf_empty", 32'(bus.instr_valid), 32'd0);
    check("rf_hold_fault", 32'(fault), 32'd1);
    check("rf_hold_rd", 32'(bus.mem_read), 32'd0);
    redirect = 1'b1; redirect_pc = 16'h0000;
    step();
    redirect = 1'b0;
    check("rf_clear", 32'(fault), 32'd0);
    step();
    check("rf_restart_rd", 32'(bus.mem_read), 32'd1);
    check("rf_restart_addr", 32'(bus.mem_address), 32'h0000);

    // asynchronous reset during streaming, then restart at reset pc
    step();
    #2; rst_n = 1'b0; #1;
    check("ar_read", 32'(bus.mem_read), 32'd0);
    check("ar_valid", 32'(bus.instr_valid), 32'd0);
    #1; rst_n = 1'b1;
    step();
    check("ar_restart_rd", 32'(bus.mem_read), 32'd1);
    check("ar_restart_addr", 32'(bus.mem_address), 32'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
